// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder.
//   state_e     : FSM encoding (IDLE / WAIT / RESP)
//   WORD_BYTES  : bytes per array word
//   idx_width() : bits needed to index n entries, never less than 1
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int WORD_BYTES = 4;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word RAM: synchronous write, combinational read.
// Ports:
//   Clk : clock, rising edge
//   We  : write enable for Idx
//   Idx : word index
//   Wd  : write data
//   Rd  : read data for Idx (combinational)
module dmem_array
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = idx_width(DEPTH_WORDS)
) (
  input  logic             Clk,
  input  logic             We,
  input  logic [IDX_W-1:0] Idx,
  input  logic [31:0]      Wd,
  output logic [31:0]      Rd
);

  logic [31:0] mem_q [DEPTH_WORDS];

  // NOTE: storage arrays get no reset; only control state needs a known value.
  always_ff @(posedge Clk) begin
    if (We) mem_q[Idx] <= Wd;
  end

  assign Rd = mem_q[Idx];

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory target for the MEM stage.
// Accepts a read or write in IDLE, holds Busy through WAIT_CYCLES wait
// states, then completes in RESP with a one-cycle Done (and AddrErr when
// the access was rejected).
// Ports:
//   Clk      : clock, rising edge
//   Rst      : synchronous active-low reset
//   MemRead  : read request
//   MemWrite : write request
//   Addr     : byte address
//   Wd       : write data
//   Rd       : registered read data, held until the next completed read
//   Busy     : pipeline stall request
//   Done     : one-cycle completion pulse
//   AddrErr  : one-cycle rejection pulse, coincident with Done
module dmem_responder
  import mem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 256,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Addr,
  input  logic [31:0] Wd,
  output logic [31:0] Rd,
  output logic        Busy,
  output logic        Done,
  output logic        AddrErr
);

  localparam int               IDX_W    = idx_width(DEPTH_WORDS);
  localparam int               CNT_W    = idx_width(WAIT_CYCLES + 1);
  localparam logic [31:0]      SPAN     = 32'(WORD_BYTES * DEPTH_WORDS);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rd_op_q, wr_op_q, err_q;
  logic [IDX_W-1:0] idx_q;
  logic [31:0]      wd_q;
  logic [31:0]      rd_q;

  // Decode of the live request inputs.
  logic             req;
  logic             below_base;
  logic [31:0]      off;
  logic             in_err;
  logic [IDX_W-1:0] in_idx;

  assign req = MemRead | MemWrite;
  // The borrow out of the subtraction flags Addr < ADDR_BASE.
  assign {below_base, off} = {1'b0, Addr} - {1'b0, ADDR_BASE};
  assign in_err = (Addr[1:0] != 2'b00) | below_base | (off >= SPAN)
                | (MemRead & MemWrite);
  assign in_idx = off[IDX_W+1:2];

  // The commit edge is the acceptance edge itself when WAIT_CYCLES=0, so the
  // datapath uses the live inputs in IDLE and the latched copy afterwards.
  logic             idle;
  logic             cur_rd, cur_wr, cur_err;
  logic [IDX_W-1:0] cur_idx;
  logic [31:0]      cur_wd;

  assign idle    = (state_q == ST_IDLE);
  assign cur_rd  = idle ? MemRead  : rd_op_q;
  assign cur_wr  = idle ? MemWrite : wr_op_q;
  assign cur_err = idle ? in_err   : err_q;
  assign cur_idx = idle ? in_idx   : idx_q;
  assign cur_wd  = idle ? Wd       : wd_q;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    Busy    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          Busy    = 1'b1;
          cnt_d   = CNT_LOAD;
          state_d = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        Busy  = 1'b1;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Commit happens on the edge entering RESP; reset in that cycle cancels it.
  logic        commit;
  logic        ram_we;
  logic [31:0] ram_rd;

  assign commit = Rst & (state_d == ST_RESP) & (state_q != ST_RESP);
  assign ram_we = commit & cur_wr & ~cur_err;

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_array (
    .Clk(Clk),
    .We (ram_we),
    .Idx(cur_idx),
    .Wd (cur_wd),
    .Rd (ram_rd)
  );

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rd_q    <= '0;
      rd_op_q <= 1'b0;
      wr_op_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (idle && req) begin
        rd_op_q <= MemRead;
        wr_op_q <= MemWrite;
        err_q   <= in_err;
      end
      if (commit && cur_rd) rd_q <= cur_err ? 32'h0 : ram_rd;
    end
  end

  // Address and data latches carry no reset; they are only read after a load.
  always_ff @(posedge Clk) begin
    if (idle && req) begin
      idx_q <= in_idx;
      wd_q  <= Wd;
    end
  end

  assign Rd      = rd_q;
  assign Done    = (state_q == ST_RESP);
  assign AddrErr = Done & err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with two wait states
// (base 0, 256 words) and one with zero wait states (base 0x100, 16 words).
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        use_w0 = 1'b0;
  logic        mr = 1'b0, mw = 1'b0;
  logic [31:0] addr = '0, wd = '0;

  logic        busy2, done2, err2, busy0, done0, err0;
  logic [31:0] rdata2, rdata0;

  logic        obs_busy, obs_done, obs_err;
  logic [31:0] obs_rd;

  always #5 clk = ~clk;

  dmem_responder #(
    .DEPTH_WORDS(256), .WAIT_CYCLES(2), .ADDR_BASE(32'h0000_0000)
  ) u_w2 (
    .Clk(clk), .Rst(rst),
    .MemRead(use_w0 ? 1'b0 : mr), .MemWrite(use_w0 ? 1'b0 : mw),
    .Addr(addr), .Wd(wd),
    .Rd(rdata2), .Busy(busy2), .Done(done2), .AddrErr(err2)
  );

  dmem_responder #(
    .DEPTH_WORDS(16), .WAIT_CYCLES(0), .ADDR_BASE(32'h0000_0100)
  ) u_w0 (
    .Clk(clk), .Rst(rst),
    .MemRead(use_w0 ? mr : 1'b0), .MemWrite(use_w0 ? mw : 1'b0),
    .Addr(addr), .Wd(wd),
    .Rd(rdata0), .Busy(busy0), .Done(done0), .AddrErr(err0)
  );

  assign obs_busy = use_w0 ? busy0  : busy2;
  assign obs_done = use_w0 ? done0  : done2;
  assign obs_err  = use_w0 ? err0   : err2;
  assign obs_rd   = use_w0 ? rdata0 : rdata2;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled
  // at the falling edge in the middle of each cycle.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        sel;      // 1 = zero-wait instance
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl[$];

  // Issue one request for a single cycle and check Busy/Done every cycle
  // up to and including the response cycle.
  task automatic run_vec(input int n, input vec_t v);
    int wc;
    wc = v.sel ? 0 : 2;
    next_cycle();
    use_w0 = v.sel; mr = v.rd; mw = v.wr; addr = v.addr; wd = v.wd;
    for (int c = 0; c <= wc; c++) begin
      @(negedge clk);
      check($sformatf("v%0d busy c%0d", n, c), 32'(obs_busy), 32'd1);
      check($sformatf("v%0d done c%0d", n, c), 32'(obs_done), 32'd0);
      next_cycle();
      if (c == 0) begin
        mr = 1'b0; mw = 1'b0; addr = 32'hFFFF_FFFF; wd = 32'h0;
      end
    end
    @(negedge clk);
    check($sformatf("v%0d resp busy", n), 32'(obs_busy), 32'd0);
    check($sformatf("v%0d resp done", n), 32'(obs_done), 32'd1);
    check($sformatf("v%0d resp err", n),  32'(obs_err),  32'(v.exp_err));
    check($sformatf("v%0d resp rd", n),   obs_rd,        v.exp_rd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            sel rd wr addr          wd            err exp_rd
    tbl.push_back('{0, 0, 1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 32'h0});
    tbl.push_back('{0, 1, 0, 32'h0000_0010, 32'h0,         0, 32'hDEAD_BEEF});
    tbl.push_back('{0, 1, 0, 32'h0000_0012, 32'h0,         1, 32'h0});
    tbl.push_back('{0, 1, 0, 32'h0000_0010, 32'h0,         0, 32'hDEAD_BEEF});
    tbl.push_back('{0, 0, 1, 32'h0000_0020, 32'hA5A5_A5A5, 0, 32'hDEAD_BEEF});
    tbl.push_back('{0, 0, 1, 32'h0000_0400, 32'h0000_0001, 1, 32'hDEAD_BEEF});
    tbl.push_back('{0, 0, 1, 32'h0000_03FC, 32'h0BAD_F00D, 0, 32'hDEAD_BEEF});
    tbl.push_back('{0, 1, 0, 32'h0000_03FC, 32'h0,         0, 32'h0BAD_F00D});
    tbl.push_back('{0, 1, 1, 32'h0000_0020, 32'hFFFF_FFFF, 1, 32'h0});
    tbl.push_back('{0, 1, 0, 32'h0000_0020, 32'h0,         0, 32'hA5A5_A5A5});
    tbl.push_back('{0, 0, 1, 32'h0000_0022, 32'h0,         1, 32'hA5A5_A5A5});
    tbl.push_back('{0, 1, 0, 32'h0000_0400, 32'h0,         1, 32'h0});
    tbl.push_back('{0, 1, 0, 32'h0000_0020, 32'h0,         0, 32'hA5A5_A5A5});
    tbl.push_back('{0, 1, 0, 32'hFFFF_FFFC, 32'h0,         1, 32'h0});
    // Zero-wait instance: base 0x100, 16 words (legal 0x100..0x13C).
    tbl.push_back('{1, 0, 1, 32'h0000_0110, 32'h600D_CAFE, 0, 32'h0});
    tbl.push_back('{1, 1, 0, 32'h0000_0110, 32'h0,         0, 32'h600D_CAFE});
    tbl.push_back('{1, 1, 0, 32'h0000_00FC, 32'h0,         1, 32'h0});
    tbl.push_back('{1, 0, 1, 32'h0000_013C, 32'h13C1_3C13, 0, 32'h0});
    tbl.push_back('{1, 1, 0, 32'h0000_013C, 32'h0,         0, 32'h13C1_3C13});
    tbl.push_back('{1, 1, 0, 32'h0000_0140, 32'h0,         1, 32'h0});

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset busy2", 32'(busy2), 32'd0);
    check("reset done2", 32'(done2), 32'd0);
    check("reset err2",  32'(err2),  32'd0);
    check("reset rd2",   rdata2,     32'h0);
    check("reset done0", 32'(done0), 32'd0);
    check("reset rd0",   rdata0,     32'h0);
    next_cycle();
    rst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) run_vec(i, tbl[i]);

    // Address change during WAIT: the latched 0x10 is used, not 0x20.
    next_cycle();
    use_w0 = 1'b0; mr = 1'b1; addr = 32'h0000_0010;
    @(negedge clk);
    check("hold c0 busy", 32'(busy2), 32'd1);
    next_cycle();
    addr = 32'h0000_0020;
    @(negedge clk);
    check("hold c1 busy", 32'(busy2), 32'd1);
    check("hold c1 done", 32'(done2), 32'd0);
    next_cycle();
    @(negedge clk);
    check("hold c2 busy", 32'(busy2), 32'd1);
    check("hold c2 done", 32'(done2), 32'd0);
    next_cycle();
    mr = 1'b0; addr = 32'h0;
    @(negedge clk);
    check("hold c3 done", 32'(done2), 32'd1);
    check("hold c3 err",  32'(err2),  32'd0);
    check("hold c3 rd",   rdata2,     32'hDEAD_BEEF);
    next_cycle();
    @(negedge clk);
    check("hold c4 done", 32'(done2), 32'd0);
    check("hold c4 busy", 32'(busy2), 32'd0);

    // Reset during WAIT cancels the write and the response.
    run_vec(100, '{0, 0, 1, 32'h0000_0020, 32'h1234_5678, 0, 32'hDEAD_BEEF});
    next_cycle();
    mw = 1'b1; addr = 32'h0000_0020; wd = 32'hCAFE_F00D;
    @(negedge clk);
    check("rst c0 busy", 32'(busy2), 32'd1);
    next_cycle();
    mw = 1'b0; rst = 1'b0;
    @(negedge clk);
    check("rst c1 busy", 32'(busy2), 32'd1);
    check("rst c1 done", 32'(done2), 32'd0);
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    check("rst c2 busy", 32'(busy2), 32'd0);
    check("rst c2 done", 32'(done2), 32'd0);
    check("rst c2 rd",   rdata2,     32'h0);
    next_cycle();
    @(negedge clk);
    check("rst c3 done", 32'(done2), 32'd0);
    run_vec(101, '{0, 1, 0, 32'h0000_0020, 32'h0, 0, 32'h1234_5678});

    // Zero-wait back-to-back: completions in cycles 1 and 3.
    next_cycle();
    use_w0 = 1'b1; mr = 1'b1; addr = 32'h0000_0110;
    @(negedge clk);
    check("b2b c0 busy", 32'(busy0), 32'd1);
    check("b2b c0 done", 32'(done0), 32'd0);
    next_cycle();
    @(negedge clk);
    check("b2b c1 busy", 32'(busy0), 32'd0);
    check("b2b c1 done", 32'(done0), 32'd1);
    check("b2b c1 err",  32'(err0),  32'd0);
    check("b2b c1 rd",   rdata0,     32'h600D_CAFE);
    next_cycle();
    addr = 32'h0000_00FC;
    @(negedge clk);
    check("b2b c2 busy", 32'(busy0), 32'd1);
    check("b2b c2 done", 32'(done0), 32'd0);
    next_cycle();
    mr = 1'b0; addr = 32'h0;
    @(negedge clk);
    check("b2b c3 done", 32'(done0), 32'd1);
    check("b2b c3 err",  32'(err0),  32'd1);
    check("b2b c3 rd",   rdata0,     32'h0);
    next_cycle();
    @(negedge clk);
    check("b2b c4 done", 32'(done0), 32'd0);
    check("b2b c4 busy", 32'(busy0), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
